serial_frame_extractor: RTL and testbench

- Parametrised successor to the lab serial pattern detector.
- Hunts a serial bit stream for a configurable header pattern, then captures a channel-ID field and a payload-length field.
- Forwards exactly that many payload bits, with a valid strobe, the captured channel and an end-of-frame pulse.
- Sits between the serial input stage and the per-channel demux/display logic.
- Contains an internal payload counter and a completed-frame counter.

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_frame_extractor_if.sv | 25 ++
 rtl/header_matcher.sv | 55 +++++
 rtl/serial_frame_extractor.sv | 138 +++++++++++++
 tb/tb_serial_frame_extractor.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame extractor: FSM encoding and default header.
package serial_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        CHAN = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_HDR_PATTERN = 4'b1101;

    function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_frame_extractor_if.sv
// Bit-stream handshake and frame outputs between the serial input stage and the demux.
interface serial_frame_extractor_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 8
);
    logic             Clk_EN;
    logic             serIn;
    logic             serOut;
    logic             serOutValid;
    logic [CH_W-1:0]  chan;
    logic             frame_done;
    logic [CNT_W-1:0] frame_count;

    // Upstream side: supplies the bit stream and observes extracted frames.
    modport master (
        output Clk_EN, serIn,
        input  serOut, serOutValid, chan, frame_done, frame_count
    );

    // Extractor side.
    modport slave (
        input  Clk_EN, serIn,
        output serOut, serOutValid, chan, frame_done, frame_count
    );
endinterface

// File: rtl/header_matcher.sv
// Sliding-window header detector; the window only counts bits seen since the last clear.
module header_matcher
    import serial_pkg::*;
#(
    parameter int unsigned          HDR_W       = 4,
    parameter logic [HDR_W-1:0]     HDR_PATTERN = HDR_W'(DEFAULT_HDR_PATTERN)
) (
    input  logic clk,
    input  logic rst,
    input  logic Clk_EN,
    input  logic serIn,
    input  logic clear,
    output logic match
);
    localparam int unsigned     HIST_W   = HDR_W - 1;
    localparam int unsigned     FILL_W   = $clog2(HDR_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(HDR_W - 1);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Next history/fill: clear wins, otherwise shift in and saturate the fill count.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (Clk_EN) begin
            if (clear) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = HIST_W'({hist_q, serIn});
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Current bit completes the window; overlapping headers fall out naturally.
    always_comb begin
        match = (fill_q == FILL_MAX) && ({hist_q, serIn} == HDR_PATTERN);
    end

endmodule

// File: rtl/serial_frame_extractor.sv
// Finds a header, captures channel and length fields, then forwards the payload bits.
module serial_frame_extractor
    import serial_pkg::*;
#(
    parameter int unsigned      HDR_W       = 4,
    parameter logic [HDR_W-1:0] HDR_PATTERN = HDR_W'(DEFAULT_HDR_PATTERN),
    parameter int unsigned      CH_W        = 2,
    parameter int unsigned      LEN_W       = 4,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_frame_extractor_if.slave  bus
);
    localparam int unsigned BC_W = max_w(CH_W, LEN_W);

    state_t           state_q, state_d;
    logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
    logic [CH_W-1:0]  chan_sh_q, chan_sh_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CH_W-1:0]  chan_asm;
    logic [LEN_W-1:0] len_asm;
    logic             hdr_clear;
    logic             hdr_match;
    logic             ser_out;
    logic             ser_valid;
    logic             done;

    // Outside HUNT the window is held empty so a new search never overlaps the payload.
    assign hdr_clear = (state_q != HUNT);

    header_matcher #(
        .HDR_W       (HDR_W),
        .HDR_PATTERN (HDR_PATTERN)
    ) u_header_matcher (
        .clk    (clk),
        .rst    (rst),
        .Clk_EN (bus.Clk_EN),
        .serIn  (bus.serIn),
        .clear  (hdr_clear),
        .match  (hdr_match)
    );

    // Next-state, field capture and output decode.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        chan_sh_d = chan_sh_q;
        chan_d    = chan_q;
        len_d     = len_q;
        fcnt_d    = fcnt_q;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        chan_asm  = CH_W'({chan_sh_q, bus.serIn});
        len_asm   = LEN_W'({len_q, bus.serIn});

        case (state_q)
            HUNT: begin
                if (bus.Clk_EN && hdr_match) begin
                    state_d  = CHAN;
                    bitcnt_d = '0;
                end
            end
            CHAN: begin
                if (bus.Clk_EN) begin
                    chan_sh_d = chan_asm;
                    bitcnt_d  = bitcnt_q + BC_W'(1);
                    if (bitcnt_q == BC_W'(CH_W - 1)) begin
                        chan_d   = chan_asm;
                        bitcnt_d = '0;
                        state_d  = LEN;
                    end
                end
            end
            LEN: begin
                if (bus.Clk_EN) begin
                    len_d    = len_asm;
                    bitcnt_d = bitcnt_q + BC_W'(1);
                    if (bitcnt_q == BC_W'(LEN_W - 1)) begin
                        bitcnt_d = '0;
                        if (len_asm == '0) begin
                            // Empty frame completes on its last length bit.
                            done    = 1'b1;
                            fcnt_d  = fcnt_q + CNT_W'(1);
                            state_d = HUNT;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                ser_out   = bus.serIn;
                ser_valid = bus.Clk_EN;
                if (bus.Clk_EN) begin
                    bitcnt_d = bitcnt_q + BC_W'(1);
                    if (LEN_W'(bitcnt_q) == len_q - LEN_W'(1)) begin
                        done    = 1'b1;
                        fcnt_d  = fcnt_q + CNT_W'(1);
                        state_d = HUNT;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and field registers; everything holds when Clk_EN is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            bitcnt_q  <= '0;
            chan_sh_q <= '0;
            chan_q    <= '0;
            len_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            chan_sh_q <= chan_sh_d;
            chan_q    <= chan_d;
            len_q     <= len_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign bus.serOut      = ser_out;
    assign bus.serOutValid = ser_valid;
    assign bus.frame_done  = done;
    assign bus.chan        = chan_q;
    assign bus.frame_count = fcnt_q;

endmodule

// File: tb/tb_serial_frame_extractor.sv
// Bench for serial_frame_extractor: directed scenarios plus random streams vs a frame parser.
module tb_serial_frame_extractor;

    localparam logic [3:0] PAT = 4'b1101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;
    logic sin = 1'b0;

    int errors = 0;
    int checks = 0;
    int tot_vld = 0;
    int tot_done = 0;

    // Reference parser state: bits since restart, position within frame, captured fields.
    bit m_buf[$];
    bit m_in_frame;
    int m_pos;
    int m_acc;
    int m_len;
    int m_chan;
    int m_count;

    bit tx_q[$];

    always #5 clk = ~clk;

    serial_frame_extractor_if #(.CH_W(2), .CNT_W(8)) ifa ();
    serial_frame_extractor_if #(.CH_W(2), .CNT_W(2)) ifb ();

    assign ifa.Clk_EN = cen;
    assign ifa.serIn  = sin;
    assign ifb.Clk_EN = cen;
    assign ifb.serIn  = sin;

    serial_frame_extractor #(
        .HDR_W(4), .HDR_PATTERN(4'b1101), .CH_W(2), .LEN_W(4), .CNT_W(8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    serial_frame_extractor #(
        .HDR_W(4), .HDR_PATTERN(4'b1101), .CH_W(2), .LEN_W(4), .CNT_W(2)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic model_reset();
        m_buf.delete();
        m_in_frame = 1'b0;
        m_pos      = 0;
        m_acc      = 0;
        m_len      = 0;
        m_chan     = 0;
        m_count    = 0;
    endtask

    // Consume one enabled bit: header search over bits since restart, then fields by offset.
    task automatic model_step(input bit b, output bit done);
        int n;
        logic [3:0] win;
        done = 1'b0;
        if (!m_in_frame) begin
            m_buf.push_back(b);
            n = m_buf.size();
            if (n >= 4) begin
                win = {m_buf[n-4], m_buf[n-3], m_buf[n-2], m_buf[n-1]};
                if (win == PAT) begin
                    m_in_frame = 1'b1;
                    m_pos      = 0;
                    m_acc      = 0;
                end
            end
        end else begin
            m_pos++;
            if (m_pos <= 2) begin
                m_acc = m_acc * 2 + int'(b);
                if (m_pos == 2) begin
                    m_chan = m_acc;
                    m_acc  = 0;
                end
            end else if (m_pos <= 6) begin
                m_acc = m_acc * 2 + int'(b);
                if (m_pos == 6) begin
                    m_len = m_acc;
                    if (m_len == 0) done = 1'b1;
                end
            end else if (m_pos - 6 == m_len) begin
                done = 1'b1;
            end
            if (done) begin
                m_count++;
                m_in_frame = 1'b0;
                m_buf.delete();
            end
        end
    endtask

    // One clock: drive inputs after negedge, compare registers and decoded outputs vs model.
    task automatic cycle(input bit en, input bit b);
        bit in_data;
        bit ev, eo, ed;
        @(negedge clk);
        cen = en;
        sin = b;
        #1;
        checks++;
        if (ifa.chan !== 2'(m_chan)) begin
            errors++;
            $display("FAIL chan: got %0d expected %0d", ifa.chan, m_chan);
        end
        checks++;
        if (ifa.frame_count !== 8'(m_count)) begin
            errors++;
            $display("FAIL frame_count: got %0d expected %0d", ifa.frame_count, m_count);
        end
        checks++;
        if (ifb.frame_count !== 2'(m_count)) begin
            errors++;
            $display("FAIL frame_count_w2: got %0d expected %0d", ifb.frame_count, m_count % 4);
        end
        in_data = m_in_frame && (m_pos >= 6);
        eo = in_data & b;
        ev = in_data & en;
        ed = 1'b0;
        if (en) model_step(b, ed);
        checks++;
        if (ifa.serOutValid !== ev) begin
            errors++;
            $display("FAIL serOutValid: got %b expected %b", ifa.serOutValid, ev);
        end
        checks++;
        if (ifa.serOut !== eo) begin
            errors++;
            $display("FAIL serOut: got %b expected %b", ifa.serOut, eo);
        end
        checks++;
        if (ifa.frame_done !== ed) begin
            errors++;
            $display("FAIL frame_done: got %b expected %b", ifa.frame_done, ed);
        end
        checks++;
        if (ifb.frame_done !== ed) begin
            errors++;
            $display("FAIL frame_done_w2: got %b expected %b", ifb.frame_done, ed);
        end
        tot_vld  += int'(ifa.serOutValid);
        tot_done += int'(ifa.frame_done);
    endtask

    // Send tx_q: mode 0 always enabled, 1 alternate with disabled cycles, 2 random gaps.
    task automatic flush(input int mode);
        foreach (tx_q[i]) begin
            if (mode == 2) begin
                while ($urandom_range(3) == 0) cycle(1'b0, 1'($urandom));
            end
            cycle(1'b1, tx_q[i]);
            if (mode == 1) cycle(1'b0, 1'($urandom));
        end
        tx_q.delete();
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) tx_q.push_back(v[i]);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b1;
        sin = 1'b1;
        #1;
        checks++;
        if (ifa.serOutValid !== 1'b0 || ifa.serOut !== 1'b0 || ifa.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b%b%b expected 000",
                     ifa.serOutValid, ifa.serOut, ifa.frame_done);
        end
        checks++;
        if (ifa.chan !== 2'd0 || ifa.frame_count !== 8'd0 || ifb.frame_count !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: got chan=%0d cnt=%0d expected 0 0",
                     ifa.chan, ifa.frame_count);
        end
        model_reset();
        @(negedge clk);
        cen = 1'b0;
        rst = 1'b0;
        tot_vld  = 0;
        tot_done = 0;
    endtask

    task automatic test_basic(input int mode, input string tag);
        test_reset();
        push_bits(32'b1101_10_0011_101, 13);
        flush(mode);
        idle();
        checks++;
        if (ifa.chan !== 2'd2) begin
            errors++;
            $display("FAIL %s_chan: got %0d expected 2", tag, ifa.chan);
        end
        checks++;
        if (tot_vld != 3 || tot_done != 1) begin
            errors++;
            $display("FAIL %s_strobes: got vld=%0d done=%0d expected 3 1", tag, tot_vld, tot_done);
        end
        checks++;
        if (ifa.frame_count !== 8'd1) begin
            errors++;
            $display("FAIL %s_count: got %0d expected 1", tag, ifa.frame_count);
        end
    endtask

    task automatic test_overlap();
        test_reset();
        push_bits(32'b0001_1101, 8);
        push_bits(32'b01_0001_0, 7);
        flush(0);
        idle();
        checks++;
        if (ifa.chan !== 2'd1 || tot_vld != 1 || ifa.frame_count !== 8'd1) begin
            errors++;
            $display("FAIL overlap: got chan=%0d vld=%0d cnt=%0d expected 1 1 1",
                     ifa.chan, tot_vld, ifa.frame_count);
        end
    endtask

    task automatic test_zero_length();
        test_reset();
        push_bits(32'b1101_11_0000, 10);
        flush(0);
        idle();
        checks++;
        if (ifa.chan !== 2'd3 || tot_vld != 0 || tot_done != 1 || ifa.frame_count !== 8'd1) begin
            errors++;
            $display("FAIL zero_len: got chan=%0d vld=%0d done=%0d cnt=%0d expected 3 0 1 1",
                     ifa.chan, tot_vld, tot_done, ifa.frame_count);
        end
        // The extractor must be hunting again right away.
        push_bits(32'b1101_10_0011_101, 13);
        flush(0);
        idle();
        checks++;
        if (ifa.frame_count !== 8'd2 || tot_vld != 3) begin
            errors++;
            $display("FAIL zero_len_next: got cnt=%0d vld=%0d expected 2 3",
                     ifa.frame_count, tot_vld);
        end
    endtask

    task automatic test_reset_mid_payload();
        test_reset();
        push_bits(32'b1101_00_0101_1, 11);
        flush(0);
        @(negedge clk);
        cen = 1'b1;
        sin = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (ifa.serOutValid !== 1'b0 || ifa.chan !== 2'd0 || ifa.frame_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset: got vld=%b chan=%0d cnt=%0d expected 0 0 0",
                     ifa.serOutValid, ifa.chan, ifa.frame_count);
        end
        model_reset();
        @(negedge clk);
        cen = 1'b0;
        rst = 1'b0;
        tot_vld  = 0;
        push_bits(32'b1101_10_0011_101, 13);
        flush(0);
        idle();
        checks++;
        if (ifa.frame_count !== 8'd1 || ifa.chan !== 2'd2 || tot_vld != 3) begin
            errors++;
            $display("FAIL mid_reset_next: got cnt=%0d chan=%0d vld=%0d expected 1 2 3",
                     ifa.frame_count, ifa.chan, tot_vld);
        end
    endtask

    task automatic test_counter_wrap();
        int exp_wrap[5] = '{1, 2, 3, 0, 1};
        test_reset();
        for (int i = 0; i < 5; i++) begin
            push_bits(32'b1101_00_0001, 10);
            tx_q.push_back(1'($urandom));
            flush(0);
            idle();
            checks++;
            if (ifb.frame_count !== 2'(exp_wrap[i])) begin
                errors++;
                $display("FAIL wrap_%0d: got %0d expected %0d", i, ifb.frame_count, exp_wrap[i]);
            end
        end
    endtask

    task automatic test_random();
        int len;
        test_reset();
        for (int f = 0; f < 40; f++) begin
            int noise = $urandom_range(6);
            for (int i = 0; i < noise; i++) tx_q.push_back(1'($urandom));
            push_bits(32'(PAT), 4);
            push_bits(32'($urandom_range(3)), 2);
            len = $urandom_range(15);
            push_bits(32'(len), 4);
            for (int i = 0; i < len; i++) tx_q.push_back(1'($urandom));
            flush(int'($urandom_range(2)));
        end
        for (int i = 0; i < 20; i++) idle();
        checks++;
        if (m_count == 0) begin
            errors++;
            $display("FAIL random_activity: got %0d frames expected nonzero", m_count);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic(0, "basic");
        test_overlap();
        test_zero_length();
        test_basic(1, "gaps");
        test_reset_mid_payload();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
